load_store_unit: RTL and testbench

- Sits between the execute stage and the byte-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, write data, write enable and funct3.
- Aligned accesses are issued as one native access. Misaligned halfword/word accesses are split into sequential byte accesses, and load bytes are reassembled with sign/zero extension.
- Out-of-range or illegal requests are rejected with an error response and never touch memory.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, memory and response signals of the load/store unit.
// slave: the unit's view. master: the execute stage / memory side view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;

  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, mem_address, mem_write_data, mem_write_enable, mem_funct3,
    output resp_valid, resp_err, resp_rdata
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, mem_address, mem_write_data, mem_write_enable, mem_funct3,
    input  resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, aligned accesses issued natively,
// misaligned halfword/word accesses split into byte accesses, bad requests
// answered with an error without touching memory.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        misal_q, misal_d;
  logic        err_q, err_d;

  // Request decode, only meaningful in StIdle.
  logic [2:0]  req_size;
  logic        req_misal;
  logic        req_illegal;
  logic [32:0] req_last_byte;
  logic        req_oor;

  always_comb begin
    unique case (bus.req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_misal = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    if (bus.req_is_store) begin
      req_illegal = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                      bus.req_funct3 == 3'b010);
    end else begin
      req_illegal = (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                     bus.req_funct3 == 3'b111);
    end
    // 33-bit sum so an address wrap counts as out of range.
    req_last_byte = {1'b0, bus.req_addr} + {30'b0, req_size} - 33'd1;
    req_oor       = req_last_byte >= 33'(MEM_BYTES);
  end

  // Index of the final byte of a misaligned access.
  logic [1:0] last_cnt;
  assign last_cnt = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  // State and captured request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      asm_q      <= 32'b0;
      cnt_q      <= 2'd0;
      misal_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      misal_q    <= misal_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: capture in idle, step bytes in access, one-cycle response.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    misal_d    = misal_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          funct3_d   = bus.req_funct3;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          asm_d      = 32'b0;
          cnt_d      = 2'd0;
          misal_d    = req_misal;
          err_d      = req_illegal || req_oor;
          state_d    = (req_illegal || req_oor) ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (!is_store_q) begin
          if (misal_q) begin
            unique case (cnt_q)
              2'd0: asm_d[7:0]   = bus.mem_read_data[7:0];
              2'd1: asm_d[15:8]  = bus.mem_read_data[7:0];
              2'd2: asm_d[23:16] = bus.mem_read_data[7:0];
              2'd3: asm_d[31:24] = bus.mem_read_data[7:0];
            endcase
          end else begin
            asm_d = bus.mem_read_data;
          end
        end
        if (!misal_q || cnt_q == last_cnt) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Byte k of the store data for split stores.
  logic [7:0] wbyte;
  always_comb begin
    unique case (cnt_q)
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
    endcase
  end

  // Outputs decoded from state; everything idles at zero outside access/response.
  always_comb begin
    bus.req_ready        = (state_q == StIdle);
    bus.resp_valid       = 1'b0;
    bus.resp_err         = 1'b0;
    bus.resp_rdata       = 32'b0;
    bus.mem_address      = 32'b0;
    bus.mem_write_data   = 32'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_funct3       = 3'b000;
    if (state_q == StAccess) begin
      bus.mem_write_enable = is_store_q;
      if (misal_q) begin
        bus.mem_address = addr_q + {30'b0, cnt_q};
        bus.mem_funct3  = is_store_q ? 3'b000 : 3'b100;
        if (is_store_q) bus.mem_write_data = {24'b0, wbyte};
      end else begin
        bus.mem_address = addr_q;
        bus.mem_funct3  = funct3_q;
        if (is_store_q) bus.mem_write_data = wdata_q;
      end
    end
    if (state_q == StResp) begin
      bus.resp_valid = 1'b1;
      bus.resp_err   = err_q;
      if (!err_q && !is_store_q) begin
        // Split LH needs sign extension; LHU/LW assembly already has zero/full upper bytes.
        if (misal_q && funct3_q == 3'b001) begin
          bus.resp_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
        end else begin
          bus.resp_rdata = asm_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write by funct3, combinational read with extension.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } wr_t;

  logic [7:0]  mem [0:4095];
  wr_t         wq[$];
  int          resp_cnt = 0;
  logic [11:0] ra;
  logic [7:0]  b0, b1, b2, b3;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      wq.push_back('{a: bus.mem_address, d: bus.mem_write_data, f: bus.mem_funct3});
      mem[bus.mem_address[11:0]] <= bus.mem_write_data[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) begin
        mem[bus.mem_address[11:0] + 12'd1] <= bus.mem_write_data[15:8];
      end
      if (bus.mem_funct3[1:0] == 2'b10) begin
        mem[bus.mem_address[11:0] + 12'd2] <= bus.mem_write_data[23:16];
        mem[bus.mem_address[11:0] + 12'd3] <= bus.mem_write_data[31:24];
      end
    end
    if (bus.resp_valid) resp_cnt++;
  end

  always_comb begin
    ra = bus.mem_address[11:0];
    b0 = mem[ra];
    b1 = mem[ra + 12'd1];
    b2 = mem[ra + 12'd2];
    b3 = mem[ra + 12'd3];
    case (bus.mem_funct3)
      3'b000:  bus.mem_read_data = {{24{b0[7]}}, b0};
      3'b100:  bus.mem_read_data = {24'b0, b0};
      3'b001:  bus.mem_read_data = {{16{b1[7]}}, b1, b0};
      3'b101:  bus.mem_read_data = {16'b0, b1, b0};
      3'b010:  bus.mem_read_data = {b3, b2, b1, b0};
      default: bus.mem_read_data = 32'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
  } vec_t;

  // Issue one request, measure latency from accept, check the response.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    wq.delete();
    bus.req_valid    = 1'b1;
    bus.req_is_store = v.st;
    bus.req_funct3   = v.f3;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    check({v.name, ".ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    check({v.name, ".latency"}, 32'(lat), 32'(v.lat));
    check({v.name, ".err"}, 32'(bus.resp_err), 32'(v.err));
    check({v.name, ".rdata"}, bus.resp_rdata, v.rdata);
    check({v.name, ".writes"}, 32'(wq.size()), 32'(v.writes));
    @(negedge clk);
    check({v.name, ".one_cycle_resp"}, 32'(bus.resp_valid), 32'd0);
  endtask

  vec_t vecs[$];
  logic [31:0] got_rd[$];
  int          got_at[$];
  int          base_resp;

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'h1234_5678;

    // Reset values, with a request pending that must be ignored.
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_err", 32'(bus.resp_err), 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    check("rst.mem_we", 32'(bus.mem_write_enable), 32'd0);
    check("rst.mem_address", bus.mem_address, 32'd0);
    check("rst.mem_wdata", bus.mem_write_data, 32'd0);
    check("rst.mem_funct3", 32'(bus.mem_funct3), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;

    // Aligned SW: one native word write.
    run_vec('{"sw_al", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1});
    if (wq.size() == 1) begin
      check("sw_al.addr", wq[0].a, 32'h10);
      check("sw_al.data", wq[0].d, 32'hDEAD_BEEF);
      check("sw_al.f3", 32'(wq[0].f), 32'd2);
    end

    // Misaligned SW: four SB writes, low byte first.
    run_vec('{"sw_mis", 1'b1, 3'b010, 32'h21, 32'h1122_3344, 1'b0, 32'h0, 5, 4});
    if (wq.size() == 4) begin
      check("sw_mis.a0", wq[0].a, 32'h21);
      check("sw_mis.d0", wq[0].d, 32'h44);
      check("sw_mis.a1", wq[1].a, 32'h22);
      check("sw_mis.d1", wq[1].d, 32'h33);
      check("sw_mis.a2", wq[2].a, 32'h23);
      check("sw_mis.d2", wq[2].d, 32'h22);
      check("sw_mis.a3", wq[3].a, 32'h24);
      check("sw_mis.d3", wq[3].d, 32'h11);
      check("sw_mis.f3", 32'(wq[3].f), 32'd0);
    end

    vecs.push_back('{"lw_al", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0});
    vecs.push_back('{"lw_mis", 1'b0, 3'b010, 32'h21, 32'h0, 1'b0, 32'h1122_3344, 5, 0});
    vecs.push_back('{"lw_mis2", 1'b0, 3'b010, 32'h22, 32'h0, 1'b0, 32'h0011_2233, 5, 0});
    vecs.push_back('{"sb_31", 1'b1, 3'b000, 32'h31, 32'hFFFF_FF80, 1'b0, 32'h0, 2, 1});
    vecs.push_back('{"sb_32", 1'b1, 3'b000, 32'h32, 32'h0000_00FF, 1'b0, 32'h0, 2, 1});
    vecs.push_back('{"lh_mis", 1'b0, 3'b001, 32'h31, 32'h0, 1'b0, 32'hFFFF_FF80, 3, 0});
    vecs.push_back('{"lhu_mis", 1'b0, 3'b101, 32'h31, 32'h0, 1'b0, 32'h0000_FF80, 3, 0});
    vecs.push_back('{"lb_al", 1'b0, 3'b000, 32'h31, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0});
    vecs.push_back('{"lbu_al", 1'b0, 3'b100, 32'h32, 32'h0, 1'b0, 32'h0000_00FF, 2, 0});
    vecs.push_back('{"sh_al", 1'b1, 3'b001, 32'h40, 32'hABCD_1234, 1'b0, 32'h0, 2, 1});
    vecs.push_back('{"lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h0000_1234, 2, 0});
    vecs.push_back('{"lw_4092", 1'b0, 3'b010, 32'd4092, 32'h0, 1'b0, 32'h0, 2, 0});
    vecs.push_back('{"lb_4095", 1'b0, 3'b000, 32'd4095, 32'h0, 1'b0, 32'h0, 2, 0});
    vecs.push_back('{"lw_4094", 1'b0, 3'b010, 32'd4094, 32'h0, 1'b1, 32'h0, 1, 0});
    vecs.push_back('{"lw_4093", 1'b0, 3'b010, 32'd4093, 32'h0, 1'b1, 32'h0, 1, 0});
    vecs.push_back('{"lh_4095", 1'b0, 3'b001, 32'd4095, 32'h0, 1'b1, 32'h0, 1, 0});
    vecs.push_back('{"sb_wrap", 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h55, 1'b1, 32'h0, 1, 0});
    vecs.push_back('{"ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0});
    vecs.push_back('{"st_f100", 1'b1, 3'b100, 32'h10, 32'h77, 1'b1, 32'h0, 1, 0});
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back with req_valid held: LW 0x10 then LBU 0x32.
    @(negedge clk);
    base_resp        = resp_cnt;
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h10;
    @(posedge clk);
    #1;
    bus.req_funct3 = 3'b100;
    bus.req_addr   = 32'h32;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2 || c == 4 || c == 5) begin
        check($sformatf("b2b.ready_c%0d", c), 32'(bus.req_ready), 32'd0);
      end
      if (c == 3) check("b2b.ready_c3", 32'(bus.req_ready), 32'd1);
      if (bus.resp_valid) begin
        got_rd.push_back(bus.resp_rdata);
        got_at.push_back(c);
        if (got_rd.size() == 2) bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b.resp_count", 32'(resp_cnt - base_resp), 32'd2);
    if (got_rd.size() == 2) begin
      check("b2b.rdata0", got_rd[0], 32'hDEAD_BEEF);
      check("b2b.at0", 32'(got_at[0]), 32'd2);
      check("b2b.rdata1", got_rd[1], 32'h0000_00FF);
      check("b2b.at1", 32'(got_at[1]), 32'd5);
    end

    // Reset during the 2nd byte of a misaligned SW.
    @(negedge clk);
    wq.delete();
    base_resp        = resp_cnt;
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h51;
    bus.req_wdata    = 32'hA1B2_C3D4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.we_before", 32'(bus.mem_write_enable), 32'd1);
    check("rstmid.addr_before", bus.mem_address, 32'h52);
    rst_n = 1'b0;
    #1;
    check("rstmid.we", 32'(bus.mem_write_enable), 32'd0);
    check("rstmid.addr", bus.mem_address, 32'd0);
    check("rstmid.wdata", bus.mem_write_data, 32'd0);
    check("rstmid.ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid.writes", 32'(wq.size()), 32'd1);
    check("rstmid.no_resp", 32'(resp_cnt - base_resp), 32'd0);
    run_vec('{"after_rst", 1'b0, 3'b010, 32'h51, 32'h0, 1'b0, 32'h0000_00D4, 5, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
